// File: rtl/ofs_plat_axi_stream_pkt_checker.sv
// AXI stream sink checker: LFSR data, tuser and length checks with stats.
// Optional halt on first error: OFS_PLAT_AXIS_CHK_STOP_ON_ERR_EN.
module ofs_plat_axi_stream_pkt_checker #(
   parameter int          TDATA_WIDTH = 512,
   parameter int          TUSER_WIDTH = 8,
   parameter int          MAX_BEATS   = 64,
   parameter int          CNT_WIDTH   = 32,
   parameter logic [31:0] SEED        = 32'h1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   tvalid,
   output logic                   tready,
   input  logic [TDATA_WIDTH-1:0] tdata,
   input  logic [TUSER_WIDTH-1:0] tuser,
   input  logic                   tlast,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [3:0]             bp_mask,
   output logic [CNT_WIDTH-1:0]   pkt_count,
   output logic [CNT_WIDTH-1:0]   beat_count,
   output logic [CNT_WIDTH-1:0]   err_count,
   output logic [CNT_WIDTH-1:0]   first_err_beat,
   output logic [2:0]             err_flags,
   output logic                   halted
);

   localparam int          REP  = TDATA_WIDTH / 32;
   localparam int          BI_W = $clog2(MAX_BEATS);
   localparam logic [31:0] POLY = 32'h80200003;

   typedef enum logic [1:0] {IDLE, SOP, MID, HALT} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             phase_q;
   logic [1:0]             phase_nx;
   logic                   tready_q, tready_d;
   logic [31:0]            lfsr_q, lfsr_nx;
   logic [BI_W-1:0]        bi_q;
   logic [CNT_WIDTH-1:0]   pkt_q, beat_q, err_q, first_q;
   logic [2:0]             flags_q;
   logic                   acc;
   logic                   data_err, user_err, len_err, any_err, pkt_end;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(
      input logic [CNT_WIDTH-1:0] v
   );
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   assign acc      = tvalid && tready_q;
   assign data_err = tdata != {REP{lfsr_q}};
   assign user_err = tuser != pkt_q[TUSER_WIDTH-1:0];
   assign len_err  = !tlast && (bi_q == BI_W'(MAX_BEATS - 1));
   assign any_err  = data_err || user_err || len_err;
   assign pkt_end  = tlast || len_err;
   assign phase_nx = phase_q + 2'd1;
   assign lfsr_nx  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);

   // Next FSM state; enable drop only takes effect between packets.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (enable) state_d = SOP;
         SOP: begin
            if (acc && !tlast) state_d = MID;
            else if (!enable)  state_d = IDLE;
         end
         MID: if (acc && pkt_end) state_d = enable ? SOP : IDLE;
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
`ifdef OFS_PLAT_AXIS_CHK_STOP_ON_ERR_EN
      if (acc && any_err) state_d = HALT;
`endif
      if (clear) state_d = IDLE;
   end

   // tready is registered from the next state and the next backpressure phase.
   always_comb begin
      tready_d = ((state_d == SOP) || (state_d == MID)) && bp_mask[phase_nx];
   end

`ifdef OFS_PLAT_AXIS_CHK_STOP_ON_ERR_EN
   logic halted_q;
   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   // All state: FSM, LFSR, beat index and statistics; clear beats an accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         phase_q  <= 2'd0;
         tready_q <= 1'b0;
         lfsr_q   <= SEED;
         bi_q     <= '0;
         pkt_q    <= '0;
         beat_q   <= '0;
         err_q    <= '0;
         first_q  <= '0;
         flags_q  <= 3'b000;
`ifdef OFS_PLAT_AXIS_CHK_STOP_ON_ERR_EN
         halted_q <= 1'b0;
`endif
      end else begin
         phase_q  <= phase_nx;
         state_q  <= state_d;
         tready_q <= tready_d;
`ifdef OFS_PLAT_AXIS_CHK_STOP_ON_ERR_EN
         halted_q <= (state_d == HALT);
`endif
         if (clear) begin
            lfsr_q  <= SEED;
            bi_q    <= '0;
            pkt_q   <= '0;
            beat_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            flags_q <= 3'b000;
         end else if (acc) begin
            lfsr_q <= lfsr_nx;
            beat_q <= sat_inc(beat_q);
            bi_q   <= pkt_end ? '0 : bi_q + BI_W'(1);
            if (pkt_end) pkt_q <= sat_inc(pkt_q);
            if (any_err) begin
               err_q   <= sat_inc(err_q);
               flags_q <= flags_q | {len_err, user_err, data_err};
               if (flags_q == 3'b000) first_q <= beat_q;
            end
         end
      end
   end

   assign tready         = tready_q;
   assign pkt_count      = pkt_q;
   assign beat_count     = beat_q;
   assign err_count      = err_q;
   assign first_err_beat = first_q;
   assign err_flags      = flags_q;

endmodule
